regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor of the single-write, dual-read register file.
- Adds configurable read-port count, a second write port, synchronous clear, an optional hardwired zero register, write-to-read bypass and an optional registered-read mode.
- Adds a per-register pending-write scoreboard for the pipelined core's hazard logic.
- Sits between decode/issue (reads, scoreboard set) and writeback (two retire lanes).

Parameters:
- BW_DATA, 32, data width per register.
- BW_ADDR, 5, address width; depth = 2**BW_ADDR.
- NUM_RD, 2, number of read ports (1..8).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data.
- RD_SYNC, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_rf_rd_addr  in  NUM_RD*BW_ADDR  read addresses; port k uses bits [k*BW_ADDR +: BW_ADDR].
- o_rf_rd_data  out  NUM_RD*BW_DATA  read data; port k uses bits [k*BW_DATA +: BW_DATA].
- o_rf_rd_busy  out  NUM_RD  scoreboard bit of each read address (same timing as o_rf_rd_data).
- i_rf_wr_en0  in  1  write lane 0 enable.
- i_rf_wr_addr0  in  BW_ADDR  write lane 0 address.
- i_rf_wr_data0  in  BW_DATA  write lane 0 data.
- i_rf_wr_en1  in  1  write lane 1 enable.
- i_rf_wr_addr1  in  BW_ADDR  write lane 1 address.
- i_rf_wr_data1  in  BW_DATA  write lane 1 data.
- i_sb_set_en  in  1  mark a destination as pending.
- i_sb_set_addr  in  BW_ADDR  address to mark pending.

Behaviour:
- Clock and reset: single clock i_clk. i_rst is synchronous and active-high. At a reset edge:
  - all registers are cleared to 0;
  - all scoreboard bits are cleared;
  - in RD_SYNC=1, o_rf_rd_data and o_rf_rd_busy registers are cleared to 0.
  - Reset overrides any write or set in the same cycle.
  - In RD_SYNC=0, outputs reflect the cleared array from the next cycle onward.
- Writes:
  - A register updates on a clock edge when its lane enable is high.
  - Lanes 0 and 1 to the same address in the same cycle: lane 1 wins; lane 0's data is discarded.
  - Disabled lanes hold contents. There is no implicit read-modify-write.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 regardless of bypass.
  - Scoreboard bit 0 is forced to 0.
- Scoreboard:
  - busy[a] is set on an edge when i_sb_set_en and i_sb_set_addr==a.
  - busy[a] is cleared on an edge when either write lane writes address a.
  - Set and clear of the same address in the same cycle: set wins (new producer issued while the old one retires).
- Read, RD_SYNC=0:
  - o_rf_rd_data[k] = array[addr_k] combinationally.
  - With BYPASS=1, if lane 1 writes addr_k this cycle the output is wr_data1; else if lane 0 writes addr_k it is wr_data0.
  - With BYPASS=1, o_rf_rd_busy[k] is 0 when addr_k is being written this cycle and not being set this cycle.
  - With BYPASS=0, reads return the pre-write contents and busy.
- Read, RD_SYNC=1:
  - Outputs are registered, presenting the value sampled at the edge.
  - BYPASS=1 gives write-first: the output after the edge equals the newly written data and the updated busy.
  - BYPASS=0 gives read-first: the old contents.
- All NUM_RD ports are independent; multiple ports may read the same address.
- No address range checks are needed, since depth equals 2**BW_ADDR.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert i_rst one cycle, then read r5 -> 0x00000000 and busy[5]=0. A write issued during the reset cycle is not stored.
- Dual-write conflict: lane0 writes r7=0x11111111 and lane1 writes r7=0x22222222 in the same cycle -> r7 reads 0x22222222. A lane0 write to r8=0x33 in a separate cycle, in parallel with lane1 r9=0x44, stores both.
- Zero register (ZERO_REG=1): write r0=0xFFFFFFFF, then read r0 -> 0. Set scoreboard on r0 -> busy stays 0.
- Bypass (RD_SYNC=0, BYPASS=1): r3 holds 0xA, a read of r3 runs during a lane0 write of 0xB -> same-cycle read gives 0xB. With BYPASS=0 the same-cycle read gives 0xA and the next cycle gives 0xB.
- Scoreboard: set r4 -> busy[4]=1 next cycle. Lane1 writes r4 with a simultaneous set r4 -> busy stays 1. A later write without set -> busy 0.
- Registered read (RD_SYNC=1, NUM_RD=4): four ports read r1..r4 holding 1..4 -> data appears one cycle after the addresses are applied, in the correct slices, and is 0 after reset.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback and the multi-port register file.
// The master side drives addresses, write lanes and scoreboard set; the slave returns read data and busy.
interface regfile_mp_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5,
    parameter int NUM_RD  = 2
);
    logic [NUM_RD*BW_ADDR-1:0] i_rf_rd_addr;
    logic [NUM_RD*BW_DATA-1:0] o_rf_rd_data;
    logic [NUM_RD-1:0]         o_rf_rd_busy;
    logic                      i_rf_wr_en0;
    logic [BW_ADDR-1:0]        i_rf_wr_addr0;
    logic [BW_DATA-1:0]        i_rf_wr_data0;
    logic                      i_rf_wr_en1;
    logic [BW_ADDR-1:0]        i_rf_wr_addr1;
    logic [BW_DATA-1:0]        i_rf_wr_data1;
    logic                      i_sb_set_en;
    logic [BW_ADDR-1:0]        i_sb_set_addr;

    modport master (
        output i_rf_rd_addr, i_rf_wr_en0, i_rf_wr_addr0, i_rf_wr_data0,
               i_rf_wr_en1, i_rf_wr_addr1, i_rf_wr_data1, i_sb_set_en, i_sb_set_addr,
        input  o_rf_rd_data, o_rf_rd_busy
    );

    modport slave (
        input  i_rf_rd_addr, i_rf_wr_en0, i_rf_wr_addr0, i_rf_wr_data0,
               i_rf_wr_en1, i_rf_wr_addr1, i_rf_wr_data1, i_sb_set_en, i_sb_set_addr,
        output o_rf_rd_data, o_rf_rd_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with pending-write scoreboard,
// optional hardwired zero register, write-to-read bypass and registered read.
module regfile_mp #(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_SYNC  = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    regfile_mp_if.slave   rf
);
    localparam int DEPTH = 2**BW_ADDR;

    logic [BW_DATA-1:0]        mem_q [DEPTH];
    logic [BW_DATA-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]          busy_q;
    logic [DEPTH-1:0]          busy_d;
    logic                      wr0_ok;
    logic                      wr1_ok;
    logic [BW_ADDR-1:0]        rd_addr [NUM_RD];
    logic [NUM_RD*BW_DATA-1:0] rd_data_c;
    logic [NUM_RD-1:0]         rd_busy_c;

    // Lane 1 is applied after lane 0 so it wins a same-address conflict.
    always_comb begin
        wr0_ok = rf.i_rf_wr_en0 && !(ZERO_REG != 0 && rf.i_rf_wr_addr0 == '0);
        wr1_ok = rf.i_rf_wr_en1 && !(ZERO_REG != 0 && rf.i_rf_wr_addr1 == '0);
        mem_d  = mem_q;
        if (wr0_ok) mem_d[rf.i_rf_wr_addr0] = rf.i_rf_wr_data0;
        if (wr1_ok) mem_d[rf.i_rf_wr_addr1] = rf.i_rf_wr_data1;
    end

    // Set is applied last so a new producer survives the retirement of the old one.
    always_comb begin
        busy_d = busy_q;
        if (rf.i_rf_wr_en0) busy_d[rf.i_rf_wr_addr0] = 1'b0;
        if (rf.i_rf_wr_en1) busy_d[rf.i_rf_wr_addr1] = 1'b0;
        if (rf.i_sb_set_en) busy_d[rf.i_sb_set_addr] = 1'b1;
        if (ZERO_REG != 0)  busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = rf.i_rf_rd_addr[k*BW_ADDR +: BW_ADDR];
        end
    end

    // Bypass reads the next-state array, which already folds in both lanes and the zero rule.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (BYPASS != 0) begin
                rd_data_c[k*BW_DATA +: BW_DATA] = mem_d[rd_addr[k]];
                if (RD_SYNC != 0) begin
                    rd_busy_c[k] = busy_d[rd_addr[k]];
                end else begin
                    rd_busy_c[k] = busy_q[rd_addr[k]] &
                        ~(((rf.i_rf_wr_en0 && rf.i_rf_wr_addr0 == rd_addr[k]) ||
                           (rf.i_rf_wr_en1 && rf.i_rf_wr_addr1 == rd_addr[k])) &&
                          !(rf.i_sb_set_en && rf.i_sb_set_addr == rd_addr[k]));
                end
            end else begin
                rd_data_c[k*BW_DATA +: BW_DATA] = mem_q[rd_addr[k]];
                rd_busy_c[k] = busy_q[rd_addr[k]];
            end
            if (ZERO_REG != 0 && rd_addr[k] == '0) begin
                rd_data_c[k*BW_DATA +: BW_DATA] = '0;
                rd_busy_c[k] = 1'b0;
            end
        end
    end

    if (RD_SYNC != 0) begin : g_sync
        logic [NUM_RD*BW_DATA-1:0] rd_data_q;
        logic [NUM_RD*BW_DATA-1:0] rd_data_d;
        logic [NUM_RD-1:0]         rd_busy_q;
        logic [NUM_RD-1:0]         rd_busy_d;

        always_comb begin
            rd_data_d = rd_data_c;
            rd_busy_d = rd_busy_c;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rd_data_q <= '0;
                rd_busy_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
                rd_busy_q <= rd_busy_d;
            end
        end

        assign rf.o_rf_rd_data = rd_data_q;
        assign rf.o_rf_rd_busy = rd_busy_q;
    end else begin : g_comb
        assign rf.o_rf_rd_data = rd_data_c;
        assign rf.o_rf_rd_busy = rd_busy_c;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Drives three register-file configurations with shared write/scoreboard traffic and
// checks them against an array-based reference of the register and pending state.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en0, wr_en1, sb_set;
    logic [4:0]  wr_addr0, wr_addr1, sb_addr;
    logic [31:0] wr_data0, wr_data1;
    logic [4:0]  ra [4];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: index 0 models a zero-register file, index 1 a plain one.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];

    always #5 clk = ~clk;

    regfile_mp_if #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(2)) ifb ();
    regfile_mp_if #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(4)) ifc ();

    assign ifa.i_rf_rd_addr = {ra[1], ra[0]};
    assign ifb.i_rf_rd_addr = {ra[1], ra[0]};
    assign ifc.i_rf_rd_addr = {ra[3], ra[2], ra[1], ra[0]};

    assign ifa.i_rf_wr_en0 = wr_en0;   assign ifb.i_rf_wr_en0 = wr_en0;   assign ifc.i_rf_wr_en0 = wr_en0;
    assign ifa.i_rf_wr_addr0 = wr_addr0; assign ifb.i_rf_wr_addr0 = wr_addr0; assign ifc.i_rf_wr_addr0 = wr_addr0;
    assign ifa.i_rf_wr_data0 = wr_data0; assign ifb.i_rf_wr_data0 = wr_data0; assign ifc.i_rf_wr_data0 = wr_data0;
    assign ifa.i_rf_wr_en1 = wr_en1;   assign ifb.i_rf_wr_en1 = wr_en1;   assign ifc.i_rf_wr_en1 = wr_en1;
    assign ifa.i_rf_wr_addr1 = wr_addr1; assign ifb.i_rf_wr_addr1 = wr_addr1; assign ifc.i_rf_wr_addr1 = wr_addr1;
    assign ifa.i_rf_wr_data1 = wr_data1; assign ifb.i_rf_wr_data1 = wr_data1; assign ifc.i_rf_wr_data1 = wr_data1;
    assign ifa.i_sb_set_en = sb_set;   assign ifb.i_sb_set_en = sb_set;   assign ifc.i_sb_set_en = sb_set;
    assign ifa.i_sb_set_addr = sb_addr; assign ifb.i_sb_set_addr = sb_addr; assign ifc.i_sb_set_addr = sb_addr;

    regfile_mp #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .RD_SYNC(0))
        u_a (.i_clk(clk), .i_rst(rst), .rf(ifa));
    regfile_mp #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0), .RD_SYNC(0))
        u_b (.i_clk(clk), .i_rst(rst), .rf(ifb));
    regfile_mp #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1), .RD_SYNC(1))
        u_c (.i_clk(clk), .i_rst(rst), .rf(ifc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic written(input logic [4:0] a);
        return (wr_en0 && wr_addr0 == a) || (wr_en1 && wr_addr1 == a);
    endfunction

    // Same-cycle view of the zero-register, bypassing file.
    function automatic logic [31:0] exp_a_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en1 && wr_addr1 == a) return wr_data1;
        if (wr_en0 && wr_addr0 == a) return wr_data0;
        return m_mem[0][a];
    endfunction

    function automatic logic exp_a_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (written(a) && !(sb_set && sb_addr == a)) return 1'b0;
        return m_busy[0][a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int z = 0; z < 2; z++)
                for (int r = 0; r < 32; r++) begin
                    m_mem[z][r]  = 32'd0;
                    m_busy[z][r] = 1'b0;
                end
        end else begin
            for (int z = 0; z < 2; z++) begin
                logic [31:0] nxt [32];
                logic        nb  [32];
                for (int r = 0; r < 32; r++) begin
                    nxt[r] = m_mem[z][r];
                    nb[r]  = m_busy[z][r];
                    if (!(z == 0 && r == 0)) begin
                        if (wr_en1 && wr_addr1 == 5'(r))      nxt[r] = wr_data1;
                        else if (wr_en0 && wr_addr0 == 5'(r)) nxt[r] = wr_data0;
                    end
                    if (sb_set && sb_addr == 5'(r)) nb[r] = 1'b1;
                    else if (written(5'(r)))        nb[r] = 1'b0;
                    if (z == 0 && r == 0) nb[r] = 1'b0;
                end
                for (int r = 0; r < 32; r++) begin
                    m_mem[z][r]  = nxt[r];
                    m_busy[z][r] = nb[r];
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #2;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("a_data", ifa.o_rf_rd_data[k*32 +: 32], exp_a_data(ra[k]));
                chk("a_busy", {31'd0, ifa.o_rf_rd_busy[k]}, {31'd0, exp_a_busy(ra[k])});
                chk("b_data", ifb.o_rf_rd_data[k*32 +: 32], m_mem[1][ra[k]]);
                chk("b_busy", {31'd0, ifb.o_rf_rd_busy[k]}, {31'd0, m_busy[1][ra[k]]});
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("c_data", ifc.o_rf_rd_data[k*32 +: 32], m_mem[0][ra[k]]);
            chk("c_busy", {31'd0, ifc.o_rf_rd_busy[k]}, {31'd0, m_busy[0][ra[k]]});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; sb_set = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; sb_addr = '0; wr_data0 = '0; wr_data1 = '0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
    endtask

    task automatic set(input logic [4:0] a);
        sb_set = 1'b1; sb_addr = a;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) ra[k] = 5'd0;
        idle(); rst = 1'b1;
        tick();

        // Reset clears contents and pending bits; a write during reset is lost.
        idle(); wr0(5'd5, 32'hDEADBEEF); tick();
        idle(); set(5'd5); tick();
        idle(); rst = 1'b1; wr1(5'd5, 32'h12345678); tick();
        idle(); ra[0] = 5'd5; #1;
        chk("rst_r5_data", ifa.o_rf_rd_data[31:0], 32'd0);
        chk("rst_r5_busy", {31'd0, ifa.o_rf_rd_busy[0]}, 32'd0);
        chk("rst_r5_b", ifb.o_rf_rd_data[31:0], 32'd0);
        tick();

        // Dual-lane conflict, then independent lanes.
        idle(); wr0(5'd7, 32'h11111111); wr1(5'd7, 32'h22222222); tick();
        idle(); wr0(5'd8, 32'h33); wr1(5'd9, 32'h44); tick();
        idle(); ra[0] = 5'd7; ra[1] = 5'd8; #1;
        chk("conflict_r7", ifa.o_rf_rd_data[31:0], 32'h22222222);
        chk("lane0_r8", ifa.o_rf_rd_data[63:32], 32'h33);
        ra[0] = 5'd9; #1;
        chk("lane1_r9", ifa.o_rf_rd_data[31:0], 32'h44);
        tick();

        // Zero register versus an ordinary r0.
        idle(); wr0(5'd0, 32'hFFFFFFFF); tick();
        idle(); set(5'd0); tick();
        idle(); ra[0] = 5'd0; #1;
        chk("zero_data", ifa.o_rf_rd_data[31:0], 32'd0);
        chk("zero_busy", {31'd0, ifa.o_rf_rd_busy[0]}, 32'd0);
        chk("plain_r0_data", ifb.o_rf_rd_data[31:0], 32'hFFFFFFFF);
        chk("plain_r0_busy", {31'd0, ifb.o_rf_rd_busy[0]}, 32'd1);
        tick();

        // Bypass versus read-before-write.
        idle(); wr0(5'd3, 32'hA); tick();
        idle(); wr0(5'd3, 32'hB); ra[0] = 5'd3; #1;
        chk("bypass_same", ifa.o_rf_rd_data[31:0], 32'hB);
        chk("nobypass_same", ifb.o_rf_rd_data[31:0], 32'hA);
        tick();
        idle(); ra[0] = 5'd3; #1;
        chk("nobypass_next", ifb.o_rf_rd_data[31:0], 32'hB);
        tick();

        // Scoreboard set, set-beats-clear, then clear.
        idle(); set(5'd4); tick();
        idle(); ra[0] = 5'd4; #1;
        chk("sb_set", {31'd0, ifa.o_rf_rd_busy[0]}, 32'd1);
        wr1(5'd4, 32'h55); set(5'd4); tick();
        idle(); #1;
        chk("sb_set_wins", {31'd0, ifa.o_rf_rd_busy[0]}, 32'd1);
        wr0(5'd4, 32'h66); tick();
        idle(); #1;
        chk("sb_clear", {31'd0, ifa.o_rf_rd_busy[0]}, 32'd0);
        tick();

        // Registered four-port read.
        idle(); wr0(5'd1, 32'd1); wr1(5'd2, 32'd2); tick();
        idle(); wr0(5'd3, 32'd3); wr1(5'd4, 32'd4); tick();
        idle(); ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; ra[3] = 5'd4;
        tick();
        for (int k = 0; k < 4; k++) chk("sync_slice", ifc.o_rf_rd_data[k*32 +: 32], 32'(k + 1));
        idle(); rst = 1'b1; tick();
        idle();
        chk("sync_rst_data", ifc.o_rf_rd_data[31:0] | ifc.o_rf_rd_data[63:32] |
                             ifc.o_rf_rd_data[95:64] | ifc.o_rf_rd_data[127:96], 32'd0);
        chk("sync_rst_busy", {28'd0, ifc.o_rf_rd_busy}, 32'd0);

        // Randomised traffic with address collisions favoured.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wr_en0   = 1'($urandom_range(0, 1));
            wr_addr0 = pick();
            wr_data0 = $urandom;
            wr_en1   = 1'($urandom_range(0, 1));
            wr_addr1 = pick();
            wr_data1 = $urandom;
            sb_set   = 1'($urandom_range(0, 1));
            sb_addr  = pick();
            for (int k = 0; k < 4; k++) ra[k] = pick();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
